// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: stalls decode around a mul/div, pulses the multdiv unit and writes its result back.
//
// Ports:
//   clock_i, reset_ni      rising-edge clock, asynchronous active-low reset
//   issue_valid_i          decode stage holds a valid instruction
//   opcode_i, alu_op_i     instruction opcode and R-type ALU op (00110 mul, 00111 div)
//   rd_i                   destination register
//   kill_i                 flush of the in-flight operation
//   md_result_i            multdiv result
//   md_exception_i         multdiv exception, valid with md_ready_i
//   md_ready_i             multdiv result valid
//   ctrl_mult_o/ctrl_div_o one-cycle start pulses
//   stall_o                freeze PC and decode
//   wb_en_o/wb_addr_o/wb_data_o  single-cycle register write-back
//
// Optional: define MULTDIV_TIMEOUT_EN to force an exception write-back after
// TIMEOUT_CYCLES BUSY cycles without md_ready_i.
module multdiv_sequencer #(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              issue_valid_i,
    input  logic [4:0]        opcode_i,
    input  logic [4:0]        alu_op_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] md_result_i,
    input  logic              md_exception_i,
    input  logic              md_ready_i,
    output logic              ctrl_mult_o,
    output logic              ctrl_div_o,
    output logic              stall_o,
    output logic              wb_en_o,
    output logic [REG_W-1:0]  wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o
);
    typedef enum logic [1:0] {IDLE, BUSY, WB} state_e;
    state_e              state_q, state_d;
    logic                is_div_q;
    logic [REG_W-1:0]    rd_q;
    logic                ctrl_mult_q, ctrl_div_q, wb_en_q;
    logic [REG_W-1:0]    wb_addr_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                detect, start, pulse, accept, timeout, finish, exc;

    assign detect = issue_valid_i && opcode_i == 5'b00000 && (alu_op_i == 5'b00110 || alu_op_i == 5'b00111);
    assign start  = state_q == IDLE && detect;
    // the start pulse marks the first BUSY cycle, in which md_ready is ignored
    assign pulse  = ctrl_mult_q | ctrl_div_q;
    assign accept = md_ready_i && !pulse;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    // cnt_q counts completed BUSY cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1
    assign timeout = state_q == BUSY && !accept && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) cnt_q <= '0;
        else           cnt_q <= state_q == BUSY ? cnt_q + CNT_W'(1) : '0;
    end
`else
    // no timeout: BUSY waits for md_ready or kill (constant false)
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    assign finish = state_q == BUSY && !kill_i && (accept || timeout);
    assign exc    = timeout || md_exception_i;

    always_comb begin
        state_d = state_q == IDLE ? (detect ? BUSY : IDLE) :
                  state_q == BUSY ? (kill_i ? IDLE : finish ? WB : BUSY) : IDLE;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            is_div_q    <= 1'b0;
            rd_q        <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_mult_q <= start && !alu_op_i[0];
            ctrl_div_q  <= start && alu_op_i[0];
            if (start) begin
                rd_q     <= rd_i;
                is_div_q <= alu_op_i[0];
            end
            // writes to r0 are dropped unless they carry an exception to r30
            wb_en_q <= finish && (exc || rd_q != '0);
            if (finish) begin
                wb_addr_q <= exc ? REG_W'(30) : rd_q;
                wb_data_q <= exc ? (is_div_q ? DATA_W'(5) : DATA_W'(4)) : md_result_i;
            end
        end
    end

    // stall is combinational in IDLE so the mul/div never leaves decode
    assign stall_o     = reset_ni && (state_q == BUSY || start);
    assign ctrl_mult_o = ctrl_mult_q;
    assign ctrl_div_o  = ctrl_div_q;
    assign wb_en_o     = wb_en_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed and random mul/div sequences checked against a transaction-level model.
module tb_multdiv_sequencer;
`ifdef MULTDIV_TIMEOUT_EN
    localparam int TO = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO = 40;
    localparam bit TO_EN = 1'b0;
`endif
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        issue_valid = 1'b0, kill = 1'b0, md_exception = 1'b0, md_ready = 1'b0;
    logic [4:0]  opcode = 5'd0, alu_op = 5'd0, rd = 5'd0;
    logic [31:0] md_result = 32'd0;
    logic        ctrl_mult, ctrl_div, stall, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    int total = 0, bad = 0;

    multdiv_sequencer #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(TO)) dut (
        .clock_i(clock), .reset_ni(reset_n), .issue_valid_i(issue_valid), .opcode_i(opcode),
        .alu_op_i(alu_op), .rd_i(rd), .kill_i(kill), .md_result_i(md_result),
        .md_exception_i(md_exception), .md_ready_i(md_ready), .ctrl_mult_o(ctrl_mult),
        .ctrl_div_o(ctrl_div), .stall_o(stall), .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_mult"}, ctrl_mult, 0);
        chk({tag, "_div"}, ctrl_div, 0);
        chk({tag, "_wben"}, wb_en, 0);
        chk({tag, "_addr"}, wb_addr, 0);
        chk({tag, "_data"}, wb_data, 0);
    endtask

    // One mul/div transaction. d = cycles after the start pulse at which md_ready arrives,
    // kill_at = BUSY cycle (0 = pulse cycle) carrying kill, or -1.
    task automatic run_op(input bit div, input logic [4:0] r, input int d, input logic [31:0] res,
                          input bit ex, input int kill_at, input bit early_rdy);
        bit to, ex_eff, en;
        int dd;
        to = TO_EN && (d + 1 > TO);
        dd = to ? TO - 1 : d;
        ex_eff = to || ex;
        issue_valid = 1'b1; opcode = 5'd0; alu_op = div ? 5'b00111 : 5'b00110; rd = r;
        #1;
        chk("det_stall", stall, 1);
        chk("det_wben", wb_en, 0);
        chk("det_ctrl", {ctrl_mult, ctrl_div}, 0);
        tick();
        rd = 5'($urandom);
        for (int k = 0; k <= dd; k++) begin
            md_ready = (k == dd && !to) || (k == 0 && early_rdy);
            md_result = (k == dd) ? res : $urandom;
            md_exception = (k == dd) ? ex : 1'($urandom);
            kill = (k == kill_at);
            #1;
            chk("busy_stall", stall, 1);
            chk("busy_mult", ctrl_mult, k == 0 && !div);
            chk("busy_div", ctrl_div, k == 0 && div);
            chk("busy_wben", wb_en, 0);
            tick();
            md_ready = 1'b0;
            if (k == kill_at) begin
                kill = 1'b0;
                issue_valid = 1'b0;
                #1;
                chk("kill_stall", stall, 0);
                chk("kill_wben", wb_en, 0);
                chk("kill_ctrl", {ctrl_mult, ctrl_div}, 0);
                tick();
                chk("kill_after_wben", wb_en, 0);
                return;
            end
        end
        // WB: instruction still in decode, detection must be suppressed; stray kill/ready ignored
        kill = 1'($urandom);
        md_ready = 1'($urandom);
        md_exception = 1'($urandom);
        #1;
        en = ex_eff || r != 5'd0;
        chk("wb_stall", stall, 0);
        chk("wb_ctrl", {ctrl_mult, ctrl_div}, 0);
        chk("wb_en", wb_en, en);
        if (en) begin
            chk("wb_addr", wb_addr, ex_eff ? 32'd30 : 32'(r));
            chk("wb_data", wb_data, ex_eff ? (div ? 32'd5 : 32'd4) : res);
        end
        issue_valid = 1'b0;
        tick();
        kill = 1'b0;
        md_ready = 1'b0;
        #1;
        chk("post_wben", wb_en, 0);
        chk("post_stall", stall, 0);
    endtask

    initial begin
        #2;
        chk_all_zero("rst");
        tick();
        issue_valid = 1'b1;
        #1;
        chk("rst_stall_gated", stall, 0);
        issue_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("idle_wben", wb_en, 0);

        run_op(1'b0, 5'd3, 17, 32'h0000_0078, 1'b0, -1, 1'b0);
        run_op(1'b1, 5'd5, 6, 32'h1234_5678, 1'b1, -1, 1'b0);
        run_op(1'b0, 5'd0, 4, 32'hdead_beef, 1'b0, -1, 1'b0);
        run_op(1'b1, 5'd9, 5, 32'h0000_00aa, 1'b0, 5, 1'b0);
        run_op(1'b0, 5'd12, 3, 32'h0bad_f00d, 1'b0, -1, 1'b1);
        run_op(1'b1, 5'd14, 2, 32'h5555_0000, 1'b0, 0, 1'b0);

        // reset in the middle of BUSY
        issue_valid = 1'b1; opcode = 5'd0; alu_op = 5'b00110; rd = 5'd9;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        issue_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("midrst_idle_stall", stall, 0);

        // back-to-back pair
        run_op(1'b0, 5'd7, 1, 32'h0000_0111, 1'b0, -1, 1'b0);
        run_op(1'b1, 5'd8, 1, 32'h0000_0222, 1'b0, -1, 1'b0);

        // long wait: exception via timeout when the counter is built in
        run_op(1'b0, 5'd11, 50, 32'h0000_0333, 1'b0, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int kat;
            kat = ($urandom_range(9, 0) == 0) ? int'($urandom_range(12, 0)) : -1;
            run_op(1'($urandom), 5'($urandom), int'($urandom_range(20, 1)), $urandom,
                   $urandom_range(3, 0) == 0, kat, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multi-cycle sequencer for the processor's multiplier/divider unit. Detects R-type mul/div instructions from the decode stage, stalls fetch/decode, issues a one-cycle start pulse to the multdiv unit, and waits for its ready handshake. Returns the result, or the exception status, as a single-cycle register write-back. Sits between the instruction decoder/control logic and the register file write port, alongside the single-cycle ALU path.

## Interface
- `DATA_W`, 32, result/write-back data width
- `REG_W`, 5, register address width
- `TIMEOUT_CYCLES`, 40, BUSY-cycle limit; used only with `MULTDIV_TIMEOUT_EN`
- Clock/reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  decode stage holds a valid instruction
- `opcode`  in  5  instruction opcode
- `alu_op`  in  5  R-type ALU op field
- `rd`  in  REG_W  destination register
- `kill`  in  1  abort in-flight operation (branch/jump flush)
- `md_result`  in  DATA_W  multdiv result
- `md_exception`  in  1  multdiv exception; valid with `md_ready`
- `md_ready`  in  1  multdiv result valid
- `ctrl_mult`  out  1  one-cycle multiply start pulse
- `ctrl_div`  out  1  one-cycle divide start pulse
- `stall`  out  1  freeze PC and decode
- `wb_en`  out  1  register-file write enable
- `wb_addr`  out  REG_W  write-back address
- `wb_data`  out  DATA_W  write-back data

## Operation
- Detect condition: `issue_valid && opcode==5'b00000 && (alu_op==5'b00110 || alu_op==5'b00111)`. `00110` is mul; `00111` is div.
- FSM states: IDLE, BUSY, WB.
- IDLE:
  - `stall` equals the detect condition, combinationally.
  - On detect, latch `rd` and the op type (mul/div), then go to BUSY.
- BUSY:
  - `stall` is 1.
  - In the first BUSY cycle only, `ctrl_mult` or `ctrl_div` (per the latched op) is 1.
  - `md_ready` is ignored during the pulse cycle. From the next cycle on, `md_ready`=1 latches the result or exception and moves to WB.
  - `kill`=1 in any BUSY cycle moves to IDLE with no write-back.
- WB:
  - `stall` is 0, so the held instruction retires.
  - `wb_en` is 1 for exactly this cycle.
  - Detection is suppressed. Next state is always IDLE.
- Write-back values:
  - Normal: `wb_addr` = latched rd, `wb_data` = `md_result`.
  - Latched rd==0 and no exception: `wb_en` stays 0.
  - Exception: `wb_addr` = 30, `wb_data` = 4 for mul, 5 for div, zero-extended to `DATA_W`.
- Core requirement: the core suppresses its normal R-type `Rwe` for mul/div. This block is the only writer for those instructions.
- `md_ready` or `md_exception` seen in IDLE or WB is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, latches and counter 0. Reset asserted mid-operation returns to IDLE asynchronously and clears outputs immediately.
- Detect at cycle N (`stall`=1 in N). Cycle N+1 is BUSY with the ctrl pulse. `md_ready` first accepted in N+2.
- `md_ready` sampled in cycle M puts `wb_en` in M+1. Minimum detect-to-write latency is 3 cycles.
- `kill` and `md_ready` in the same BUSY cycle: `kill` wins, no write-back.
- `kill` in IDLE or WB: no effect.
- Back-to-back mul/div: the second instruction is detected in the first IDLE cycle after WB. No instruction is lost.
- `wb_addr`/`wb_data` are registered and stable during WB. They hold their last value otherwise.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - A BUSY-cycle counter resets to 0 on entering BUSY and increments every BUSY cycle.
  - If it reaches `TIMEOUT_CYCLES` without `md_ready`, the FSM goes to WB with exception semantics: r30 ← 4 (mul) or 5 (div).
  - `kill` still takes priority over the timeout.
- `MULTDIV_TIMEOUT_EN` undefined: no counter. BUSY waits indefinitely for `md_ready` or `kill`.

## Test plan
- mul, rd=3: `md_ready` 17 cycles after the pulse with `md_result`=0x0000_0078. Required: `ctrl_mult` high exactly 1 cycle, `stall` high continuously until WB, then `wb_en`=1, `wb_addr`=3, `wb_data`=0x78 for 1 cycle.
- div, rd=5: `md_ready` with `md_exception`=1. Required: `wb_addr`=30, `wb_data`=5, `ctrl_div` pulsed once, `ctrl_mult` never.
- mul, rd=0, normal completion. Required: `wb_en` stays 0; `stall` still drops in the WB cycle.
- `kill` and `md_ready` asserted together in BUSY. Required: no `wb_en`, IDLE next cycle, `stall`=0.
- `reset` low mid-BUSY, then a back-to-back mul/div pair. Required: immediate IDLE with all outputs 0; then two separate pulses and two WB cycles in order.
- With `MULTDIV_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: mul with no `md_ready`. Required: WB after 8 BUSY cycles, r30 ← 4.
